// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer
// Command front end for the PicoBlaze I2C checkout engine. It takes one
// write command at a time, raises the engine's execute input and waits for
// busy to rise and then fall. It then returns the engine result, or a timeout
// indication, on a valid/ready response port. Transaction and timeout
// counters are exposed for on-chip debug probes.
module i2c_txn_sequencer #(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_address,
    input  logic [1:0]  cmd_numbytes,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_result,
    output logic        rsp_timeout,
    output logic        i2c_execute,
    output logic [6:0]  i2c_address,
    output logic [1:0]  i2c_numbytes,
    output logic [31:0] i2c_data,
    input  logic        i2c_busy,
    input  logic [1:0]  i2c_result,
    output logic [15:0] txn_count,
    output logic [7:0]  timeout_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    // Last timer value before a stalled LAUNCH or WAIT_DONE is abandoned.
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q,         state_d;
    logic [CNT_W-1:0]  timer_q,         timer_d;
    logic              execute_q,       execute_d;
    logic [6:0]        address_q,       address_d;
    logic [1:0]        numbytes_q,      numbytes_d;
    logic [31:0]       data_q,          data_d;
    logic              rsp_valid_q,     rsp_valid_d;
    logic [1:0]        rsp_result_q,    rsp_result_d;
    logic              rsp_timeout_q,   rsp_timeout_d;
    logic [15:0]       txn_count_q,     txn_count_d;
    logic [7:0]        timeout_count_q, timeout_count_d;

    logic              accept;
    logic              timer_expired;
    logic              abort;

    // Commands are only taken while idle and the engine is quiet. The gate on
    // busy also swallows a transaction still running after a local reset.
    assign cmd_ready     = ~reset & (state_q == IDLE) & ~i2c_busy;
    assign accept        = cmd_valid & cmd_ready;
    assign timer_expired = (timer_q == TIMER_LAST);

    // Next-state logic; every register holds unless a transition changes it.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        execute_d       = execute_q;
        address_d       = address_q;
        numbytes_d      = numbytes_q;
        data_d          = data_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_result_d    = rsp_result_q;
        rsp_timeout_d   = rsp_timeout_q;
        txn_count_d     = txn_count_q;
        timeout_count_d = timeout_count_q;
        abort           = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    address_d  = cmd_address;
                    numbytes_d = cmd_numbytes;
                    data_d     = cmd_data;
                    timer_d    = '0;
                    execute_d  = 1'b1;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                // Busy already high on entry counts as the acknowledge too.
                if (i2c_busy) begin
                    execute_d = 1'b0;
                    timer_d   = '0;
                    state_d   = WAIT_DONE;
                end else if (timer_expired) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                // Engine writes result and clears busy together, so the
                // result is valid in the same cycle busy is seen low.
                if (!i2c_busy) begin
                    rsp_result_d  = i2c_result;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    txn_count_d   = txn_count_q + 16'd1;
                    state_d       = RESP;
                end else if (timer_expired) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared abandon path for a stall in either LAUNCH or WAIT_DONE.
        if (abort) begin
            execute_d     = 1'b0;
            rsp_timeout_d = 1'b1;
            rsp_result_d  = 2'b11;
            rsp_valid_d   = 1'b1;
            if (timeout_count_q != 8'hFF) begin
                timeout_count_d = timeout_count_q + 8'd1;
            end
            state_d = RESP;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            execute_q       <= 1'b0;
            address_q       <= '0;
            numbytes_q      <= '0;
            data_q          <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_result_q    <= '0;
            rsp_timeout_q   <= 1'b0;
            txn_count_q     <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            execute_q       <= execute_d;
            address_q       <= address_d;
            numbytes_q      <= numbytes_d;
            data_q          <= data_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_result_q    <= rsp_result_d;
            rsp_timeout_q   <= rsp_timeout_d;
            txn_count_q     <= txn_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign i2c_execute   = execute_q;
    assign i2c_address   = address_q;
    assign i2c_numbytes  = numbytes_q;
    assign i2c_data      = data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign txn_count     = txn_count_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: an engine stand-in is scripted per transaction
// (ack delay, busy duration, result, response backpressure) and the expected
// cycle-by-cycle behaviour is computed arithmetically from those numbers.
module tb_i2c_txn_sequencer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_address;
    logic [1:0]  cmd_numbytes;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_result;
    logic        rsp_timeout;
    logic        i2c_execute;
    logic [6:0]  i2c_address;
    logic [1:0]  i2c_numbytes;
    logic [31:0] i2c_data;
    logic        i2c_busy;
    logic [1:0]  i2c_result;
    logic [15:0] txn_count;
    logic [7:0]  timeout_count;

    int n_checks = 0;
    int n_fail   = 0;
    int txn_exp  = 0;
    int to_exp   = 0;

    always #5 clk = ~clk;

    i2c_txn_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_address   (cmd_address),
        .cmd_numbytes  (cmd_numbytes),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_timeout   (rsp_timeout),
        .i2c_execute   (i2c_execute),
        .i2c_address   (i2c_address),
        .i2c_numbytes  (i2c_numbytes),
        .i2c_data      (i2c_data),
        .i2c_busy      (i2c_busy),
        .i2c_result    (i2c_result),
        .txn_count     (txn_count),
        .timeout_count (timeout_count)
    );

    task automatic chk(input string name, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", name, field, obs, exp);
        end
    endtask

    // One command. ack: cycles after the first LAUNCH cycle until busy rises
    // (>= T means never). dur: cycles busy stays high. bp: extra cycles the
    // response is held off before rsp_ready is given.
    task automatic run_txn(input string name, input logic [6:0] a, input logic [1:0] nb,
                           input logic [31:0] d, input int ack, input int dur,
                           input logic [1:0] res, input int bp, input bit verbose);
        int         exit_c;
        int         last_launch;
        bit         exp_to;
        logic [1:0] exp_res;
        bit         busy_now;

        if (ack >= T) begin
            exit_c = T; last_launch = T; exp_to = 1'b1; exp_res = 2'b11;
        end else begin
            last_launch = 1 + ack;
            if (dur <= T) begin
                exit_c = 1 + ack + dur; exp_to = 1'b0; exp_res = res;
            end else begin
                exit_c = 1 + ack + T; exp_to = 1'b1; exp_res = 2'b11;
            end
        end

        // Cycle 0: present the command to an idle sequencer.
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_address  = a;
        cmd_numbytes = nb;
        cmd_data     = d;
        i2c_busy     = 1'b0;
        rsp_ready    = 1'b0;
        #1;
        chk(name, "cmd_ready_idle", 32'(cmd_ready), 32'd1);

        for (int c = 1; c <= exit_c + 1 + bp; c++) begin
            @(negedge clk);
            // Keep offering different commands; none may be taken.
            cmd_valid    = 1'b1;
            cmd_address  = 7'($urandom);
            cmd_numbytes = 2'($urandom);
            cmd_data     = $urandom;

            chk(name, "execute",   32'(i2c_execute),  32'(c <= last_launch));
            chk(name, "rsp_valid", 32'(rsp_valid),    32'(c > exit_c));
            chk(name, "address",   32'(i2c_address),  32'(a));
            chk(name, "numbytes",  32'(i2c_numbytes), 32'(nb));
            chk(name, "data",      i2c_data,          d);
            if (c > exit_c) begin
                chk(name, "rsp_result",  32'(rsp_result),  32'(exp_res));
                chk(name, "rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
            end

            busy_now   = (ack < T) && (c >= 1 + ack) && (c <= ack + dur) && (c <= exit_c);
            i2c_busy   = busy_now;
            i2c_result = (ack < T && c >= 1 + ack + dur) ? res : 2'($urandom);
            rsp_ready  = (c == exit_c + 1 + bp);
            #1;
            chk(name, "cmd_ready_busy", 32'(cmd_ready), 32'd0);
        end

        if (exp_to) to_exp = (to_exp < 255) ? to_exp + 1 : 255;
        else        txn_exp = (txn_exp + 1) % 65536;

        // Back in IDLE.
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        i2c_busy  = 1'b0;
        chk(name, "rsp_valid_after", 32'(rsp_valid),     32'd0);
        chk(name, "execute_after",   32'(i2c_execute),   32'd0);
        chk(name, "txn_count",       32'(txn_count),     32'(txn_exp));
        chk(name, "timeout_count",   32'(timeout_count), 32'(to_exp));
        #1;
        chk(name, "cmd_ready_after", 32'(cmd_ready), 32'd1);
        if (verbose)
            $display("txn %s addr=0x%0h nb=%0d data=0x%08h ack=%0d dur=%0d -> timeout=%0b result=%0d txn=%0d to=%0d",
                     name, a, nb, d, ack, dur, exp_to, exp_res, txn_exp, to_exp);
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b1;
        cmd_address  = '0;
        cmd_numbytes = '0;
        cmd_data     = '0;
        rsp_ready    = 1'b0;
        i2c_busy     = 1'b0;
        i2c_result   = '0;

        // Reset behaviour: ready held low during reset, outputs cleared.
        repeat (3) @(negedge clk);
        chk("reset", "cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
        chk("reset", "execute",       32'(i2c_execute),   32'd0);
        chk("reset", "rsp_valid",     32'(rsp_valid),     32'd0);
        chk("reset", "address",       32'(i2c_address),   32'd0);
        chk("reset", "data",          i2c_data,           32'd0);
        chk("reset", "txn_count",     32'(txn_count),     32'd0);
        chk("reset", "timeout_count", 32'(timeout_count), 32'd0);
        cmd_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_txn("single",      7'h50, 2'd2, 32'hDDCCBBAA, 3, 10, 2'b00, 0,  1'b1);
        run_txn("nack",        7'h21, 2'd1, 32'h12345678, 2, 7,  2'b01, 1,  1'b1);
        run_txn("no_ack",      7'h3C, 2'd3, 32'hCAFEF00D, 99, 0, 2'b00, 0,  1'b1);
        run_txn("backpress",   7'h11, 2'd0, 32'h0BADBEEF, 1, 4,  2'b10, 50, 1'b1);
        run_txn("after_bp",    7'h12, 2'd1, 32'h00C0FFEE, 1, 3,  2'b00, 0,  1'b1);
        run_txn("coincident",  7'h44, 2'd2, 32'h13579BDF, 1, T,  2'b10, 0,  1'b1);
        run_txn("wait_tmo",    7'h45, 2'd2, 32'h2468ACE0, 1, T+1, 2'b10, 0, 1'b1);
        run_txn("glitch",      7'h46, 2'd0, 32'hA5A5A5A5, 0, 5,  2'b01, 0,  1'b1);

        // Reset while in WAIT_DONE with the engine still busy.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_address = 7'h70; cmd_numbytes = 2'd3; cmd_data = 32'hFEEDFACE;
        @(negedge clk);
        cmd_valid = 1'b0; i2c_busy = 1'b1;
        @(negedge clk);
        chk("rst_mid", "execute_wait", 32'(i2c_execute), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        txn_exp = 0; to_exp = 0;
        chk("rst_mid", "execute",       32'(i2c_execute),   32'd0);
        chk("rst_mid", "rsp_valid",     32'(rsp_valid),     32'd0);
        chk("rst_mid", "address",       32'(i2c_address),   32'd0);
        chk("rst_mid", "numbytes",      32'(i2c_numbytes),  32'd0);
        chk("rst_mid", "data",          i2c_data,           32'd0);
        chk("rst_mid", "rsp_result",    32'(rsp_result),    32'd0);
        chk("rst_mid", "rsp_timeout",   32'(rsp_timeout),   32'd0);
        chk("rst_mid", "txn_count",     32'(txn_count),     32'd0);
        chk("rst_mid", "timeout_count", 32'(timeout_count), 32'd0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rst_mid", "cmd_ready_gated", 32'(cmd_ready), 32'd0);
            @(negedge clk);
            chk("rst_mid", "execute_gated", 32'(i2c_execute), 32'd0);
        end
        i2c_busy  = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("rst_mid", "cmd_ready_released", 32'(cmd_ready), 32'd1);
        $display("txn rst_mid reset in WAIT_DONE, ready gated until busy dropped");
        run_txn("post_reset", 7'h71, 2'd1, 32'h01020304, 2, 6, 2'b00, 0, 1'b1);

        // Randomized mix, including missing acks and long busy periods.
        for (int i = 0; i < 30; i++) begin
            int ack;
            ack = ($urandom_range(0, 4) == 0) ? T + 4 : int'($urandom_range(0, 4));
            run_txn($sformatf("rand%0d", i), 7'($urandom), 2'($urandom), $urandom,
                    ack, int'($urandom_range(1, T + 2)), 2'($urandom),
                    int'($urandom_range(0, 3)), 1'b1);
        end

        // Drive the timeout counter into saturation.
        while (to_exp < 255)
            run_txn("sat", 7'h7F, 2'd0, $urandom, 99, 0, 2'b00, 0, 1'b0);
        run_txn("sat_hold1", 7'h7E, 2'd0, $urandom, 99, 0, 2'b00, 0, 1'b1);
        run_txn("sat_hold2", 7'h7D, 2'd0, $urandom, 99, 0, 2'b00, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
